approx_add_err_monitor: RTL and testbench
=========================================

Name: approx_add_err_monitor

Overview:
- Downstream consumer of an approximate W-bit adder under characterisation.
- Takes each operand pair together with the approximate adder's (W+1)-bit result and computes the exact sum internally.
- Accumulates error statistics over a window of N_SAMPLES accepted samples: error count, absolute-error sum for MAE, worst-case error and its operands, and signed bias.
- Presents the results through a valid/ready handshake, then starts a fresh window.

Parameters:
- W, 8, operand width; the approximate result is W+1 bits.
- N_SAMPLES, 65536, samples per window; must be a power of two, at least 2.
- CNT_W, $clog2(N_SAMPLES)+1, width of the sample and error counters.
- ACC_W, W+1+$clog2(N_SAMPLES), width of the absolute-error accumulator; cannot overflow.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous abort: discard the window and restart
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_approx  in  W+1  approximate adder output for (in_a, in_b)
- res_valid  out  1  window results valid
- res_ready  in  1  results consumed when res_valid && res_ready
- err_count  out  CNT_W  samples with in_approx != exact sum
- abs_err_sum  out  ACC_W  sum of |in_approx - exact|
- signed_err_sum  out  ACC_W+1  two's-complement sum of (in_approx - exact)
- max_err  out  W+1  worst absolute error in the window
- max_a  out  W  operand A of the first sample reaching max_err
- max_b  out  W  operand B of the first sample reaching max_err

Behaviour:
- Reset (asynchronous, rst=1):
  - all outputs 0 except in_ready;
  - FSM to ACCUM; counters, accumulators and pipeline valids to 0;
  - in_ready rises on the first clock edge after rst deasserts.
- Reset mid-window discards all partial results.
- Exact sum: zero-extend in_a and in_b to W+1 bits and add.
- Error: e = in_approx - exact, computed in W+2 bits signed; |e| is W+1 bits.
- Pipeline:
  - S1 registers exact, e and |e| plus the operands, with valid v1.
  - S2 updates the accumulators on v1.
  - Latency from acceptance to accumulator update: 2 clocks. Fully pipelined, one sample per clock.
- Accumulator update on v1:
  - abs_err_sum += |e|; signed_err_sum += sign-extended e;
  - err_count += (|e| != 0);
  - if |e| > max_err (strictly greater), load max_err, max_a and max_b. Ties keep the earlier sample.
  - A window with all-zero error reports max_a = max_b = 0.
- FSM states:
  - ACCUM:
    - in_ready = 1 while the accepted count is below N_SAMPLES;
    - on acceptance of sample N_SAMPLES, in_ready drops the next cycle and the FSM moves to DRAIN.
  - DRAIN:
    - in_ready = 0;
    - wait until v1 and S2 are empty (2 cycles), then move to REPORT.
  - REPORT:
    - res_valid = 1; outputs stable; in_ready = 0;
    - on res_valid && res_ready, go to ACCUM with counters and accumulators zeroed on that edge;
    - in_ready = 1 on the next cycle.
- Result outputs hold the accumulator values in every state; they are meaningful only while res_valid = 1.
- clear:
  - In ACCUM or DRAIN: flush the pipeline, zero the state, return to ACCUM. in_ready = 0 during the clear cycle, so a simultaneous in_valid is not accepted.
  - In REPORT: drop the results without a handshake and go to ACCUM.
  - clear wins over res_ready when both are asserted.
- An in_valid stall leaves the state unchanged. There is no combinational path from in_valid to in_ready.
- res_ready held high is allowed: REPORT lasts exactly 1 cycle.

Decomposition:
- Package approx_err_pkg:
  - FSM enum state_t {ACCUM, DRAIN, REPORT};
  - localparam functions for CNT_W and ACC_W from W and N_SAMPLES.
- Sub-module approx_err_calc (combinational):
  - inputs a, b, approx;
  - outputs exact, e (signed), abs_e.
  - Instantiated ahead of the S1 registers and reusable by formal harnesses.

Test Plan:
- Reset, then one window with N_SAMPLES=4: samples (a,b,approx) = (3,1,6), (0,0,0), (5,2,7), (255,255,510) -> err_count=1, abs_err_sum=2, signed_err_sum=+2, max_err=2, max_a=3, max_b=1, res_valid 3 cycles after the 4th acceptance.
- Negative bias, N_SAMPLES=4: (2,2,1) twice, (1,0,0) twice -> err_count=4, abs_err_sum=8, signed_err_sum=-8, max_err=3, max_a=2, max_b=2 (first tie kept).
- Backpressure: hold res_ready=0 for 10 cycles in REPORT -> outputs stable and in_ready=0 throughout; res_ready=1 -> next cycle in_ready=1 with all accumulators 0.
- clear together with in_valid after 2 accepted samples -> that sample is not accepted; the next window of 4 reports only post-clear statistics.
- Assert rst asynchronously mid-DRAIN -> outputs 0 immediately with no clock edge, in_ready=1 after the first post-reset edge.
- Exhaustive run with W=8, N_SAMPLES=65536, in_approx = exact+1 for all pairs -> err_count=65536, abs_err_sum=65536, max_err=1, max_a=0, max_b=0.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// No ports. Provides:
//   state_t     - window FSM states
//   calc_cnt_w  - sample/error counter width for a window of n samples
//   calc_acc_w  - absolute-error accumulator width (cannot overflow over a window)
package approx_err_pkg;

   typedef enum logic [1:0] {
      ACCUM,
      DRAIN,
      REPORT
   } state_t;

   function automatic int calc_cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int calc_acc_w(input int w, input int n);
      return w + 1 + $clog2(n);
   endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Combinational error calculation for one operand pair of the approximate adder.
// Kept free of state so formal harnesses can reuse it directly.
// Ports:
//   a, b    in  W     operands
//   approx  in  W+1   approximate adder result
//   exact   out W+1   exact sum of zero-extended operands
//   e       out W+2   signed error approx - exact
//   abs_e   out W+1   |e|
module approx_err_calc #(
   parameter int W = 8
) (
   input  logic [W-1:0]        a,
   input  logic [W-1:0]        b,
   input  logic [W:0]          approx,
   output logic [W:0]          exact,
   output logic signed [W+1:0] e,
   output logic [W:0]          abs_e
);

   always_comb begin
      exact = {1'b0, a} + {1'b0, b};
      e     = $signed({1'b0, approx}) - $signed({1'b0, exact});
      // |e| never exceeds 2^(W+1)-1, so the top bit of the negation is always 0.
      abs_e = e[W+1] ? (W+1)'(-e) : e[W:0];
   end

endmodule

// File: rtl/approx_add_err_monitor.sv
// Error-statistics monitor for an approximate W-bit adder under characterisation.
// Accepts operand pairs plus the approximate result, accumulates error count,
// absolute/signed error sums and the worst-case error over N_SAMPLES samples,
// then offers the results over a valid/ready handshake and starts a new window.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clear                 synchronous abort of the current window
//   in_valid/in_ready     sample handshake; in_a, in_b, in_approx carry the sample
//   res_valid/res_ready   result handshake
//   err_count             samples with a non-zero error
//   abs_err_sum           sum of |approx - exact|
//   signed_err_sum        two's-complement sum of (approx - exact)
//   max_err, max_a, max_b worst |error| and the operands of its first occurrence
//
// state  | meaning
// ACCUM  | accepting samples until N_SAMPLES have been taken
// DRAIN  | input closed, last sample still moving through S1/S2
// REPORT | results valid, waiting for res_ready (or clear)
module approx_add_err_monitor
   import approx_err_pkg::*;
#(
   parameter int W         = 8,
   parameter int N_SAMPLES = 65536,
   parameter int CNT_W     = calc_cnt_w(N_SAMPLES),
   parameter int ACC_W     = calc_acc_w(W, N_SAMPLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W:0]       in_approx,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] abs_err_sum,
   output logic [ACC_W:0]   signed_err_sum,
   output logic [W:0]       max_err,
   output logic [W-1:0]     max_a,
   output logic [W-1:0]     max_b
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_SAMPLES - 1);
   localparam int               LP_EXT  = ACC_W + 1 - (W + 2);

   state_t r_state, w_state_nxt;
   logic   r_rdy, w_rdy_nxt;
   logic   w_zero;
   logic   w_accept;

   logic [W:0]          w_exact;
   logic signed [W+1:0] w_e;
   logic [W:0]          w_abs;

   logic             r_v1;
   logic [W:0]       r_exact;
   logic [W:0]       r_approx;
   logic [W+1:0]     r_e;
   logic [W:0]       r_abs;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [ACC_W-1:0] r_abs_sum;
   logic [ACC_W:0]   r_sgn_sum;
   logic [W:0]       r_max;
   logic [W-1:0]     r_max_a;
   logic [W-1:0]     r_max_b;

   approx_err_calc #(.W(W)) u_calc (
      .a      (in_a),
      .b      (in_b),
      .approx (in_approx),
      .exact  (w_exact),
      .e      (w_e),
      .abs_e  (w_abs)
   );

   // clear masks the ready so a sample offered in the clear cycle is refused.
   assign in_ready  = r_rdy & ~clear;
   assign w_accept  = in_valid & in_ready;
   assign res_valid = (r_state == REPORT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACCUM;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rdy   <= w_rdy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rdy_nxt   = r_rdy;
      w_zero      = 1'b0;
      if (clear) begin
         w_state_nxt = ACCUM;
         w_rdy_nxt   = 1'b1;
         w_zero      = 1'b1;
      end else begin
         case (r_state)
            ACCUM: begin
               w_rdy_nxt = 1'b1;
               if (w_accept && (r_cnt == LP_LAST)) begin
                  w_state_nxt = DRAIN;
                  w_rdy_nxt   = 1'b0;
               end
            end
            DRAIN: begin
               w_rdy_nxt = 1'b0;
               // Once v1 is clear, S2 has already absorbed the final sample.
               if (!r_v1) w_state_nxt = REPORT;
            end
            REPORT: begin
               w_rdy_nxt = 1'b0;
               if (res_ready) begin
                  w_state_nxt = ACCUM;
                  w_rdy_nxt   = 1'b1;
                  w_zero      = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ACCUM;
               w_rdy_nxt   = 1'b1;
               w_zero      = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1      <= 1'b0;
         r_exact   <= '0;
         r_approx  <= '0;
         r_e       <= '0;
         r_abs     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_err_cnt <= '0;
         r_abs_sum <= '0;
         r_sgn_sum <= '0;
         r_max     <= '0;
         r_max_a   <= '0;
         r_max_b   <= '0;
      end else begin
         r_v1 <= w_accept & ~w_zero;
         if (w_accept) begin
            r_exact  <= w_exact;
            r_approx <= in_approx;
            r_e      <= w_e;
            r_abs    <= w_abs;
            r_a      <= in_a;
            r_b      <= in_b;
         end
         if (w_zero) begin
            r_cnt     <= '0;
            r_err_cnt <= '0;
            r_abs_sum <= '0;
            r_sgn_sum <= '0;
            r_max     <= '0;
            r_max_a   <= '0;
            r_max_b   <= '0;
         end else begin
            if (w_accept) r_cnt <= r_cnt + 1'b1;
            if (r_v1) begin
               r_abs_sum <= r_abs_sum + ACC_W'(r_abs);
               r_sgn_sum <= r_sgn_sum + {{LP_EXT{r_e[W+1]}}, r_e};
               r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, (r_approx != r_exact)};
               // Strictly greater: ties keep the earlier sample's operands.
               if (r_abs > r_max) begin
                  r_max   <= r_abs;
                  r_max_a <= r_a;
                  r_max_b <= r_b;
               end
            end
         end
      end
   end

   assign err_count      = r_err_cnt;
   assign abs_err_sum    = r_abs_sum;
   assign signed_err_sum = r_sgn_sum;
   assign max_err        = r_max;
   assign max_a          = r_max_a;
   assign max_b          = r_max_b;

endmodule

// File: tb/tb_approx_add_err_monitor.sv
module tb_approx_add_err_monitor;

   localparam int NS  = 4;
   localparam int CW  = 3;
   localparam int AW  = 11;
   localparam int NB  = 65536;
   localparam int CWB = 17;
   localparam int AWB = 25;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small-window instance
   logic          rst, clear, in_valid, in_ready, res_valid, res_ready;
   logic [7:0]    in_a, in_b;
   logic [8:0]    in_approx;
   logic [CW-1:0] err_count;
   logic [AW-1:0] abs_err_sum;
   logic [AW:0]   signed_err_sum;
   logic [8:0]    max_err;
   logic [7:0]    max_a, max_b;

   // Full-size exhaustive instance
   logic           b_rst, b_clear, b_in_valid, b_in_ready, b_res_valid, b_res_ready;
   logic [7:0]     b_in_a, b_in_b;
   logic [8:0]     b_in_approx;
   logic [CWB-1:0] b_err_count;
   logic [AWB-1:0] b_abs_err_sum;
   logic [AWB:0]   b_signed_err_sum;
   logic [8:0]     b_max_err;
   logic [7:0]     b_max_a, b_max_b;

   approx_add_err_monitor #(.W(8), .N_SAMPLES(NS)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
      .res_valid(res_valid), .res_ready(res_ready),
      .err_count(err_count), .abs_err_sum(abs_err_sum),
      .signed_err_sum(signed_err_sum), .max_err(max_err),
      .max_a(max_a), .max_b(max_b)
   );

   approx_add_err_monitor #(.W(8), .N_SAMPLES(NB)) dut_big (
      .clk(clk), .rst(b_rst), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_a(b_in_a), .in_b(b_in_b), .in_approx(b_in_approx),
      .res_valid(b_res_valid), .res_ready(b_res_ready),
      .err_count(b_err_count), .abs_err_sum(b_abs_err_sum),
      .signed_err_sum(b_signed_err_sum), .max_err(b_max_err),
      .max_a(b_max_a), .max_b(b_max_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Window model: the samples accepted since the window opened.
   int q_a[$], q_b[$], q_ap[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_a.delete(); q_b.delete(); q_ap.delete();
      end else if (clear || (res_valid && res_ready)) begin
         q_a.delete(); q_b.delete(); q_ap.delete();
      end else if (in_valid && in_ready) begin
         q_a.push_back(int'(in_a));
         q_b.push_back(int'(in_b));
         q_ap.push_back(int'(in_approx));
      end
   end

   // Whenever results are presented, they must match statistics recomputed
   // from the accepted samples with plain arithmetic.
   always @(negedge clk) begin
      int ec, as, ss, me, ma, mb, d, ad;
      if (!rst && res_valid) begin
         ec = 0; as = 0; ss = 0; me = 0; ma = 0; mb = 0;
         for (int i = 0; i < q_a.size(); i++) begin
            d  = q_ap[i] - (q_a[i] + q_b[i]);
            ad = (d < 0) ? -d : d;
            if (d != 0) ec++;
            as += ad;
            ss += d;
            if (ad > me) begin
               me = ad; ma = q_a[i]; mb = q_b[i];
            end
         end
         chk("m_win_size", q_a.size(), NS);
         chk("m_in_ready_in_report", in_ready, 0);
         chk("m_err_count", err_count, ec);
         chk("m_abs_err_sum", abs_err_sum, as);
         chk("m_signed_err_sum", $signed(signed_err_sum), ss);
         chk("m_max_err", max_err, me);
         chk("m_max_a", max_a, ma);
         chk("m_max_b", max_b, mb);
      end
   end

   task automatic send(input int a, input int b, input int ap);
      int n;
      @(negedge clk);
      in_a      = 8'(a);
      in_b      = 8'(b);
      in_approx = 9'(ap);
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_res();
      int n;
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) chk("res_timeout", 0, 1);
   endtask

   task automatic chk_stats(input string t, input int ec, input int as, input int ss,
                            input int me, input int ma, input int mb);
      chk({t, "_err_count"}, err_count, ec);
      chk({t, "_abs_err_sum"}, abs_err_sum, as);
      chk({t, "_signed_err_sum"}, $signed(signed_err_sum), ss);
      chk({t, "_max_err"}, max_err, me);
      chk({t, "_max_a"}, max_a, ma);
      chk({t, "_max_b"}, max_b, mb);
   endtask

   task automatic handshake(input string t);
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({t, "_post_in_ready"}, in_ready, 1);
      chk({t, "_post_res_valid"}, res_valid, 0);
      chk_stats({t, "_post"}, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic small_tests();
      int lat;
      logic [50:0] snap;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
      in_a = '0; in_b = '0; in_approx = '0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk_stats("rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_rel_in_ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1 chk("rst_rel_in_ready_after_edge", in_ready, 1);

      // Window 1: one error of +2
      send(3, 1, 6); send(0, 0, 0); send(5, 2, 7); send(255, 255, 510);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("t1_latency", lat, 3);
      chk_stats("t1", 1, 2, 2, 2, 3, 1);
      handshake("t1");

      // Window 2: negative bias, tie keeps the first sample; then backpressure
      send(2, 2, 1); send(2, 2, 1); send(1, 0, 0); send(1, 0, 0);
      idle();
      wait_res();
      chk_stats("t2", 4, 8, -8, 3, 2, 2);
      snap = {err_count, abs_err_sum, signed_err_sum, max_err, max_a, max_b};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_stable", ({err_count, abs_err_sum, signed_err_sum, max_err, max_a, max_b} == snap), 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_res_valid", res_valid, 1);
      end
      handshake("t2");

      // Window 3: clear after two samples, with a sample offered in the clear cycle
      send(7, 7, 0); send(9, 9, 1);
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1; in_a = 8'd50; in_b = 8'd50; in_approx = 9'd0;
      #1 chk("clr_in_ready", in_ready, 0);
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      chk_stats("clr_zero", 0, 0, 0, 0, 0, 0);
      send(10, 20, 31); send(1, 1, 2); send(0, 0, 0); send(100, 100, 199);
      idle();
      wait_res();
      chk_stats("t3", 2, 2, 0, 1, 10, 20);
      handshake("t3");

      // Window 4: asynchronous reset in DRAIN
      send(3, 1, 6); send(0, 0, 0); send(5, 2, 7); send(255, 255, 510);
      idle();
      @(negedge clk);
      chk("drain_res_valid", res_valid, 0);
      chk("drain_err_count", err_count, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_res_valid", res_valid, 0);
      chk_stats("arst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("arst_rel_in_ready_before_edge", in_ready, 0);
      @(posedge clk);
      #1 chk("arst_rel_in_ready_after_edge", in_ready, 1);
   endtask

   task automatic big_test();
      int idx, cyc, n;
      b_rst = 1'b1; b_clear = 1'b0; b_res_ready = 1'b0; b_in_valid = 1'b0;
      b_in_a = '0; b_in_b = '0; b_in_approx = '0;
      repeat (2) @(negedge clk);
      b_rst = 1'b0;
      idx = 0; cyc = 0;
      while (idx < NB && cyc < 70000) begin
         @(negedge clk);
         cyc++;
         b_in_a      = 8'(idx >> 8);
         b_in_b      = 8'(idx);
         b_in_approx = {1'b0, b_in_a} + {1'b0, b_in_b} + 9'd1;
         b_in_valid  = 1'b1;
         if (b_in_ready) idx++;
      end
      chk("big_all_accepted", idx, NB);
      @(negedge clk);
      b_in_valid = 1'b0;
      n = 0;
      while (!b_res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("big_res_valid", b_res_valid, 1);
      chk("big_err_count", b_err_count, 65536);
      chk("big_abs_err_sum", b_abs_err_sum, 65536);
      chk("big_signed_err_sum", $signed(b_signed_err_sum), 65536);
      chk("big_max_err", b_max_err, 1);
      chk("big_max_a", b_max_a, 0);
      chk("big_max_b", b_max_b, 0);
   endtask

   initial begin
      fork
         small_tests();
         big_test();
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
